// File: rtl/param_regfile_sb.sv
// param_regfile_sb: 2R/1W register file with write-through bypass and a per-register busy scoreboard; ports clk, rst, rd_addr1/2 -> rd_data1/2 + busy1/2, wr_en/wr_addr/wr_data, rsv_en/rsv_addr, busy_any
module param_regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy_any
);
    localparam bit ZR = (ZERO_REG != 0);
    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy, busy_nxt;
    logic wr_ok, rsv_ok, hit1, hit2;
    assign wr_ok  = wr_en & ~rst & ~(ZR & (wr_addr == '0));
    assign rsv_ok = rsv_en & ~(ZR & (rsv_addr == '0));
    assign hit1   = wr_ok & (wr_addr == rd_addr1);
    assign hit2   = wr_ok & (wr_addr == rd_addr2);
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) busy_nxt[wr_addr] = 1'b0;
        if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) regs[wr_addr] <= wr_data;
            busy <= busy_nxt;
        end
    end
    assign rd_data1 = hit1 ? wr_data : regs[rd_addr1];
    assign rd_data2 = hit2 ? wr_data : regs[rd_addr2];
    assign busy1    = busy[rd_addr1] & ~hit1;
    assign busy2    = busy[rd_addr2] & ~hit2;
    assign busy_any = |busy;
endmodule

// File: tb/tb_param_regfile_sb.sv
// tb_param_regfile_sb: self-checking bench for param_regfile_sb (directed table, reset/zero-reg sequences, random vs. model, 32x32 sweep)
module tb_param_regfile_sb;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic [3:0]  a_r1, a_r2, a_wa, a_ra;
    logic [15:0] a_d1, a_d2, a_wd;
    logic        a_b1, a_b2, a_we, a_re, a_any;
    logic [4:0]  b_r1, b_r2, b_wa, b_ra;
    logic [31:0] b_d1, b_d2, b_wd;
    logic        b_b1, b_b2, b_we, b_re, b_any;

    param_regfile_sb ua (
        .clk(clk), .rst(rst), .rd_addr1(a_r1), .rd_addr2(a_r2), .rd_data1(a_d1), .rd_data2(a_d2),
        .busy1(a_b1), .busy2(a_b2), .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd),
        .rsv_en(a_re), .rsv_addr(a_ra), .busy_any(a_any));

    param_regfile_sb #(.WIDTH(32), .NUM_REGS(32), .ADDR_W(5), .ZERO_REG(0)) ub (
        .clk(clk), .rst(rst), .rd_addr1(b_r1), .rd_addr2(b_r2), .rd_data1(b_d1), .rd_data2(b_d2),
        .busy1(b_b1), .busy2(b_b2), .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd),
        .rsv_en(b_re), .rsv_addr(b_ra), .busy_any(b_any));

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic a_drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                           input logic re, input logic [3:0] ra, input logic [3:0] r1, input logic [3:0] r2);
        a_we = we; a_wa = wa; a_wd = wd; a_re = re; a_ra = ra; a_r1 = r1; a_r2 = r2;
    endtask

    typedef struct {
        logic we; logic [3:0] wa; logic [15:0] wd;
        logic re; logic [3:0] ra;
        logic [3:0] r1, r2;
        logic [15:0] e1, e2;
        logic eb1, eb2, eany;
    } vec_t;
    vec_t tbl[14];

    logic [15:0] m_reg [16];
    logic [15:0] m_busy;
    logic [15:0] e1, e2;
    logic [31:0] pat;

    initial begin
        tbl[0]  = '{1, 7, 16'h1234, 0, 0, 7, 7, 16'h1234, 16'h1234, 0, 0, 0};
        tbl[1]  = '{0, 0, 16'h0000, 0, 0, 7, 7, 16'h1234, 16'h1234, 0, 0, 0};
        tbl[2]  = '{1, 0, 16'hFFFF, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
        tbl[3]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
        tbl[4]  = '{0, 0, 16'h0000, 1, 9, 9, 9, 16'h0000, 16'h0000, 0, 0, 0};
        tbl[5]  = '{0, 0, 16'h0000, 0, 0, 9, 9, 16'h0000, 16'h0000, 1, 1, 1};
        tbl[6]  = '{1, 9, 16'h00AA, 0, 0, 9, 9, 16'h00AA, 16'h00AA, 0, 0, 1};
        tbl[7]  = '{0, 0, 16'h0000, 0, 0, 9, 9, 16'h00AA, 16'h00AA, 0, 0, 0};
        tbl[8]  = '{1, 4, 16'h0042, 1, 4, 4, 4, 16'h0042, 16'h0042, 0, 0, 0};
        tbl[9]  = '{0, 0, 16'h0000, 0, 0, 4, 4, 16'h0042, 16'h0042, 1, 1, 1};
        tbl[10] = '{1, 6, 16'h0066, 1, 4, 4, 6, 16'h0042, 16'h0066, 1, 0, 1};
        tbl[11] = '{0, 0, 16'h0000, 0, 0, 4, 6, 16'h0042, 16'h0066, 1, 0, 1};
        tbl[12] = '{1, 4, 16'h0043, 0, 0, 4, 6, 16'h0043, 16'h0066, 0, 0, 1};
        tbl[13] = '{0, 0, 16'h0000, 0, 0, 4, 7, 16'h0043, 16'h1234, 0, 0, 0};

        a_drive(0, 0, 0, 0, 0, 3, 5);
        b_we = 0; b_wa = 0; b_wd = 0; b_re = 0; b_ra = 0; b_r1 = 0; b_r2 = 0;
        #1;
        chk("reset_d1", 32'(a_d1), 0);
        chk("reset_b2", 32'(a_b2), 0);
        chk("reset_any", 32'(a_any), 0);
        tick();
        rst = 0;

        foreach (tbl[i]) begin
            a_drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].r1, tbl[i].r2);
            #1;
            chk($sformatf("vec%0d_d1", i), 32'(a_d1), 32'(tbl[i].e1));
            chk($sformatf("vec%0d_d2", i), 32'(a_d2), 32'(tbl[i].e2));
            chk($sformatf("vec%0d_b1", i), 32'(a_b1), 32'(tbl[i].eb1));
            chk($sformatf("vec%0d_b2", i), 32'(a_b2), 32'(tbl[i].eb2));
            chk($sformatf("vec%0d_any", i), 32'(a_any), 32'(tbl[i].eany));
            tick();
        end

        // asynchronous reset between edges, with a write attempted while held
        a_drive(1, 3, 16'hBEEF, 1, 5, 3, 5);
        tick();
        a_drive(0, 0, 0, 0, 0, 3, 5);
        #1;
        chk("pre_rst_d1", 32'(a_d1), 32'hBEEF);
        chk("pre_rst_b2", 32'(a_b2), 1);
        #1;
        rst = 1;
        a_drive(1, 3, 16'h1111, 1, 3, 3, 5);
        #1;
        chk("async_rst_d1", 32'(a_d1), 0);
        chk("async_rst_b2", 32'(a_b2), 0);
        chk("async_rst_any", 32'(a_any), 0);
        tick();
        rst = 0;
        a_drive(0, 0, 0, 0, 0, 3, 3);
        #1;
        chk("rst_wr_ignored_d1", 32'(a_d1), 0);
        chk("rst_rsv_ignored_b1", 32'(a_b1), 0);
        chk("rst_rsv_ignored_any", 32'(a_any), 0);
        tick();

        // random traffic against a behavioural model
        foreach (m_reg[i]) m_reg[i] = 0;
        m_busy = 0;
        for (int n = 0; n < 400; n++) begin
            a_drive(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom),
                    4'($urandom), 4'($urandom));
            #1;
            e1 = (a_we && a_wa == a_r1 && a_wa != 0) ? a_wd : m_reg[a_r1];
            e2 = (a_we && a_wa == a_r2 && a_wa != 0) ? a_wd : m_reg[a_r2];
            chk("rnd_d1", 32'(a_d1), 32'(e1));
            chk("rnd_d2", 32'(a_d2), 32'(e2));
            chk("rnd_b1", 32'(a_b1), 32'(m_busy[a_r1] && !(a_we && a_wa == a_r1)));
            chk("rnd_b2", 32'(a_b2), 32'(m_busy[a_r2] && !(a_we && a_wa == a_r2)));
            chk("rnd_any", 32'(a_any), 32'(|m_busy));
            if (a_we && a_wa != 0) begin
                m_reg[a_wa] = a_wd;
                m_busy[a_wa] = 0;
            end
            if (a_re && a_ra != 0) m_busy[a_ra] = 1;
            tick();
        end
        a_drive(0, 0, 0, 0, 0, 0, 0);

        // ZERO_REG=0: register 0 is ordinary
        b_we = 1; b_wa = 0; b_wd = 32'hFFFFFFFF; b_re = 1; b_ra = 0; b_r1 = 0; b_r2 = 0;
        tick();
        b_we = 0; b_re = 0;
        #1;
        chk("nz_reg0_d1", b_d1, 32'hFFFFFFFF);
        chk("nz_reg0_b1", 32'(b_b1), 1);
        chk("nz_reg0_any", 32'(b_any), 1);

        // 32x32 sweep: address-dependent pattern, every pair on both ports
        for (int i = 0; i < 32; i++) begin
            b_we = 1; b_wa = 5'(i); b_wd = i * 32'h01010101;
            tick();
        end
        b_we = 0;
        #1;
        chk("sweep_any", 32'(b_any), 0);
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) begin
                b_r1 = 5'(i); b_r2 = 5'(j);
                #1;
                pat = i * 32'h01010101;
                chk($sformatf("sweep_d1_%0d", i), b_d1, pat);
                pat = j * 32'h01010101;
                chk($sformatf("sweep_d2_%0d", j), b_d2, pat);
            end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
